// File: rtl/cdc_handshake_tx.sv
// Sender half of a four-phase req/ack CDC link.
// Holds tx_data stable while req/ack complete a full handshake.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_valid,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic                  send_ready,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  ack_async,
  output logic                  done,
  output logic                  err,
  input  logic                  clr_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    ack_meta_q;
  logic                    ack_sync_q;
  logic                    tmo;

  // Only ack_sync_q may be used by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= ack_async;
      ack_sync_q <= ack_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tmo = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;
    send_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        send_ready = !ack_sync_q;
        if (send_valid && !ack_sync_q) begin
          data_d  = send_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_sync_q) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_REL;
        end else if (tmo) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REL: begin
        if (!ack_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERR: begin
        req_d = 1'b0;
        // A clear is dropped while the remote still holds ack.
        if (clr_err && !ack_sync_q) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign req     = req_q;
  assign tx_data = data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Sender half of a four-phase req/ack clock-domain-crossing link. It accepts a parallel word from the local `clk` domain and holds it stable on `tx_data`. It signals the remote domain with a level `req`, and completes the transfer once the remote receiver's `ack`, brought back through an internal two-flop synchronizer, has risen and then fallen. A timeout watchdog flags a stuck remote side.

## Interface
- `DATA_WIDTH`, default 8: width of the transferred word.
- `TIMEOUT_CYCLES`, default 255: maximum cycles allowed in either handshake phase; legal range 4..65535.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `send_valid`  in  1: local producer has a word.
- `send_data`  in  DATA_WIDTH: word to send; sampled only on accept.
- `send_ready`  out  1: block can accept a word.
- `req`  out  1: registered request level to the remote domain.
- `tx_data`  out  DATA_WIDTH: registered, held stable from accept until the handshake completes.
- `ack_async`  in  1: acknowledge from the remote domain; asynchronous to `clk`.
- `done`  out  1: one-cycle pulse when a transfer completes.
- `err`  out  1: sticky timeout flag.
- `clr_err`  in  1: clears `err` and leaves the ERROR state.

## Operation
- Internal `ack_meta`/`ack_sync` two-flop synchronizer on `ack_async`, both reset to 0. The FSM uses only `ack_sync`.
- States: IDLE, REQ, RELEASE, ERROR. Reset state is IDLE.
- IDLE:
  - `send_ready` = (`ack_sync`==0). A stray high ack blocks acceptance.
  - Accept = `send_valid` && `send_ready`. On accept: `tx_data` <= `send_data`, `req` <= 1, counter <= 0, go to REQ.
- REQ:
  - `req`=1. If `ack_sync`==1: `req` <= 0, counter <= 0, go to RELEASE.
  - Otherwise the counter increments.
- RELEASE:
  - `req`=0. If `ack_sync`==0: go to IDLE with `done` <= 1 for one cycle.
  - Otherwise the counter increments.
- Timeout: in REQ or RELEASE, if counter == TIMEOUT_CYCLES-1 and the exit condition is false, then `req` <= 0, `err` <= 1, go to ERROR. If the ack condition and the timeout occur on the same edge, the ack condition wins.
- ERROR:
  - `req`=0, `send_ready`=0, `tx_data` held.
  - Exit to IDLE on an edge where `clr_err`=1 and `ack_sync`=0. `err` <= 0 on that edge.
  - If `clr_err`=1 while `ack_sync`=1, the request is ignored; `clr_err` must be reasserted.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It never wraps, because the timeout fires first.
- `send_data` is ignored outside accept. `tx_data` changes only on accept.

## Timing
- Reset values: `req`=0, `tx_data`=0, `done`=0, `err`=0, `send_ready`=1 (ack_sync=0), state IDLE.
- Reset mid-transfer: `req` drops to 0 immediately (asynchronous) and the transfer is abandoned with no `done`. The remote receiver sees a normal req fall.
- Zero-delay loopback (`ack_async` tied to `req`), accept at edge k:
  - `req` high after k; `ack_sync` high after k+2; `req` low after k+3.
  - `ack_sync` low after k+5; IDLE with `done`=1 and `send_ready`=1 after k+6; `done` low after k+7.
  - Next accept at earliest on edge k+7, giving 7 cycles per word.
- `req` is glitch-free: it is driven directly from a flop.
- `tx_data` is stable at least 2 cycles before any remote sampling of `ack`-qualified data, because `req` and `tx_data` update on the same edge.

## Test plan
- Reset, then loopback `ack_async`=`req`, `send_data`=8'hA5 accepted at edge k -> `tx_data`=8'hA5 and `req`=1 after k; `done` pulse in the cycle after k+6; `send_ready` low for cycles k+1..k+6.
- Back-to-back: `send_valid` held high with words 8'h01, 8'h02, 8'h03 under loopback -> three `done` pulses, 7 cycles apart. `tx_data` sequence is 01, 02, 03, and each value is held through its full handshake.
- `ack_async` tied to 0, TIMEOUT_CYCLES=8 -> `err`=1 and `req`=0 on the 8th edge after entering REQ. `send_ready` stays 0 until `clr_err` is pulsed, after which the block returns to IDLE with `err`=0.
- `ack_async` held 1 after the rise (remote stuck) -> timeout in RELEASE sets `err`. `clr_err` is ignored while `ack_sync`=1; after ack falls and `clr_err` is reasserted, the block returns to IDLE.
- Stray `ack_async`=1 while IDLE -> `send_ready`=0 two cycles later and no accept occurs despite `send_valid`=1. Accept resumes 2 cycles after ack falls.
- `rst` asserted mid-REQ, between clock edges -> `req`, `err`, `done` and `tx_data` go to 0 immediately. After `rst` release, `send_ready`=1 and no `done` is ever produced for the aborted word.
